// File: rtl/latch_frame_decoder_if.sv
// Byte stream in, decoded frame results out, for latch_frame_decoder.
// The master drives bytes; the slave (the decoder) returns frame status.
interface latch_frame_decoder_if;
    logic [7:0]  i_Data;
    logic        i_ByteValid;
    logic        o_FrameValid;
    logic [31:0] o_Payload;
    logic [2:0]  o_Length;
    logic        o_Busy;
    logic [7:0]  o_ErrCount;

    modport master (
        output i_Data, i_ByteValid,
        input  o_FrameValid, o_Payload, o_Length, o_Busy, o_ErrCount
    );

    modport slave (
        input  i_Data, i_ByteValid,
        output o_FrameValid, o_Payload, o_Length, o_Busy, o_ErrCount
    );
endinterface

// File: rtl/latch_frame_decoder.sv
// Decodes SYNC / LEN / PAYLOAD / CHECKSUM frames arriving one byte per latch strobe.
// Checksum is the mod-256 sum of the length byte and all payload bytes.
module latch_frame_decoder #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input logic                  i_LatchClock,
    input logic                  i_Reset,
    latch_frame_decoder_if.slave io_Bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHECK   = 2'd3;

    localparam logic [7:0] MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       r_State,    w_State;
    logic [2:0]       r_Len,      w_Len;
    logic [7:0]       r_Sum,      w_Sum;
    logic [2:0]       r_Index,    w_Index;
    logic [7:0]       r_Timer,    w_Timer;
    logic [3:0][7:0]  r_Buf,      w_Buf;
    logic [31:0]      r_Payload,  w_Payload;
    logic [2:0]       r_Length,   w_Length;
    logic             r_Valid,    w_Valid;
    logic [7:0]       r_ErrCount, w_ErrCount;
    logic             w_Err;

    always_comb begin
        w_State   = r_State;
        w_Len     = r_Len;
        w_Sum     = r_Sum;
        w_Index   = r_Index;
        w_Timer   = r_Timer;
        w_Buf     = r_Buf;
        w_Payload = r_Payload;
        w_Length  = r_Length;
        w_Valid   = 1'b0;
        w_Err     = 1'b0;

        if (io_Bus.i_ByteValid) begin
            w_Timer = '0;
            case (r_State)
                ST_IDLE: begin
                    if (io_Bus.i_Data == SYNC_BYTE) w_State = ST_LEN;
                end
                ST_LEN: begin
                    if (io_Bus.i_Data != 8'd0 && io_Bus.i_Data <= MAX_LEN_B) begin
                        w_State = ST_PAYLOAD;
                        w_Len   = io_Bus.i_Data[2:0];
                        w_Sum   = io_Bus.i_Data;
                        w_Index = '0;
                    end else begin
                        w_State = ST_IDLE;
                        w_Err   = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    w_Buf[r_Index[1:0]] = io_Bus.i_Data;
                    w_Sum               = r_Sum + io_Bus.i_Data;
                    w_Index             = r_Index + 3'd1;
                    if (r_Index == r_Len - 3'd1) w_State = ST_CHECK;
                end
                default: begin
                    w_State = ST_IDLE;
                    if (io_Bus.i_Data == r_Sum) begin
                        w_Valid  = 1'b1;
                        w_Length = r_Len;
                        // Bytes beyond this frame's length may be stale from an earlier frame.
                        for (int k = 0; k < 4; k++) begin
                            w_Payload[8*k +: 8] = (3'(k) < r_Len) ? r_Buf[k] : 8'd0;
                        end
                    end else begin
                        w_Err = 1'b1;
                    end
                end
            endcase
        end else if (r_State != ST_IDLE) begin
            if (r_Timer == TIMEOUT_LAST) begin
                w_State = ST_IDLE;
                w_Timer = '0;
                w_Err   = 1'b1;
            end else begin
                w_Timer = r_Timer + 8'd1;
            end
        end else begin
            w_Timer = '0;
        end

        w_ErrCount = r_ErrCount;
        if (w_Err && r_ErrCount != 8'hFF) w_ErrCount = r_ErrCount + 8'd1;
    end

    always_ff @(posedge i_LatchClock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State    <= ST_IDLE;
            r_Len      <= '0;
            r_Sum      <= '0;
            r_Index    <= '0;
            r_Timer    <= '0;
            r_Buf      <= '0;
            r_Payload  <= '0;
            r_Length   <= '0;
            r_Valid    <= 1'b0;
            r_ErrCount <= '0;
        end else begin
            r_State    <= w_State;
            r_Len      <= w_Len;
            r_Sum      <= w_Sum;
            r_Index    <= w_Index;
            r_Timer    <= w_Timer;
            r_Buf      <= w_Buf;
            r_Payload  <= w_Payload;
            r_Length   <= w_Length;
            r_Valid    <= w_Valid;
            r_ErrCount <= w_ErrCount;
        end
    end

    assign io_Bus.o_FrameValid = r_Valid;
    assign io_Bus.o_Payload    = r_Payload;
    assign io_Bus.o_Length     = r_Length;
    assign io_Bus.o_Busy       = (r_State != ST_IDLE);
    assign io_Bus.o_ErrCount   = r_ErrCount;
endmodule

// File: tb/tb_latch_frame_decoder.sv
// Directed and randomized byte streams checked every cycle against a frame-level model.
module tb_latch_frame_decoder;
    localparam int MAX_LEN = 4;
    localparam int TIMEOUT = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk;
    logic rst_n;
    latch_frame_decoder_if bus ();

    latch_frame_decoder #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAX_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_LatchClock (clk),
        .i_Reset      (rst_n),
        .io_Bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Frame-level model: bytes after a sync are collected and judged once complete.
    bit          m_in;
    int          m_q[$];
    int          m_idle;
    logic [31:0] m_pay;
    logic [2:0]  m_len;
    int          m_err;
    bit          m_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_q.delete(); m_idle = 0; m_pay = '0; m_len = '0; m_err = 0; m_valid = 0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_step(input bit v, input int d);
        int sum;
        m_valid = 0;
        if (!v) begin
            if (m_in) begin
                m_idle++;
                if (m_idle >= TIMEOUT) begin
                    m_in = 0;
                    model_err();
                end
            end
            return;
        end
        m_idle = 0;
        if (!m_in) begin
            if (d == int'(SYNC)) begin
                m_in = 1;
                m_q.delete();
            end
            return;
        end
        m_q.push_back(d);
        if (m_q[0] == 0 || m_q[0] > MAX_LEN) begin
            m_in = 0;
            model_err();
            return;
        end
        if (m_q.size() == m_q[0] + 2) begin
            sum = 0;
            for (int i = 0; i < m_q.size() - 1; i++) sum += m_q[i];
            m_in = 0;
            if (sum % 256 == d) begin
                m_valid = 1;
                m_len   = 3'(m_q[0]);
                m_pay   = '0;
                for (int k = 0; k < m_q[0]; k++) m_pay[8*k +: 8] = 8'(m_q[k+1]);
            end else begin
                model_err();
            end
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".valid"}, 32'(bus.o_FrameValid), 32'(m_valid));
        chk({where, ".payload"}, bus.o_Payload, m_pay);
        chk({where, ".length"}, 32'(bus.o_Length), 32'(m_len));
        chk({where, ".busy"}, 32'(bus.o_Busy), 32'(m_in));
        chk({where, ".errcnt"}, 32'(bus.o_ErrCount), 32'(m_err));
    endtask

    task automatic step(input bit v, input logic [7:0] d, input string where);
        bus.i_ByteValid = v;
        bus.i_Data      = d;
        @(posedge clk);
        model_step(v, int'(d));
        #1;
        check_outputs(where);
    endtask

    task automatic send(input int bytes[$], input string where);
        foreach (bytes[i]) step(1'b1, 8'(bytes[i]), where);
    endtask

    task automatic do_reset(input string where);
        #2;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_outputs({where, ".inreset"});
        rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n, input string where);
        for (int i = 0; i < n; i++) step(1'b0, 8'(SYNC), where);
    endtask

    task automatic rand_frame();
        int len, sum, kind;
        int f[$];
        kind = int'($urandom_range(0, 9));
        len  = int'($urandom_range(1, MAX_LEN));
        f.push_back(int'(SYNC));
        if (kind == 0) begin
            f.push_back($urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(5, 255)));
        end else begin
            f.push_back(len);
            sum = len;
            for (int i = 0; i < len; i++) begin
                f.push_back(int'($urandom_range(0, 255)));
                sum += f[f.size() - 1];
            end
            f.push_back(kind == 1 ? (sum + 1) % 256 : sum % 256);
        end
        foreach (f[i]) begin
            if ($urandom_range(0, 4) == 0) idle_cycles(int'($urandom_range(1, 3)), "rand.gap");
            if ($urandom_range(0, 60) == 0) idle_cycles(TIMEOUT + 2, "rand.longgap");
            step(1'b1, 8'(f[i]), "rand");
        end
        if ($urandom_range(0, 3) == 0) step(1'b1, 8'($urandom_range(0, 255)), "rand.noise");
    endtask

    initial begin
        bus.i_Data = '0;
        bus.i_ByteValid = 1'b0;
        rst_n = 1'b1;
        do_reset("reset");
        @(posedge clk);
        #1;

        // Good two-byte frame.
        send('{'hA5, 'h02, 'h11, 'h22, 'h35}, "good2");
        chk("good2.payload_const", bus.o_Payload, 32'h0000_2211);
        chk("good2.length_const", 32'(bus.o_Length), 32'd2);
        step(1'b0, 8'h00, "good2.after");

        // Bad checksum keeps previous payload.
        send('{'hA5, 'h01, 'h10, 'hFF}, "badsum");
        chk("badsum.err_const", 32'(bus.o_ErrCount), 32'd1);

        // Bad lengths then a full four-byte frame.
        send('{'hA5, 'h00}, "badlen0");
        send('{'hA5, 'h05}, "badlen5");
        send('{'hA5, 'h04, 'h01, 'h02, 'h03, 'h04, 'h0E}, "good4");
        chk("good4.payload_const", bus.o_Payload, 32'h0403_0201);

        // Timeout mid-frame, then recovery.
        send('{'hA5, 'h02, 'h11}, "tmo.pre");
        idle_cycles(TIMEOUT, "tmo.idle");
        send('{'hA5, 'h01, 'h77, 'h78}, "tmo.post");

        // Sync byte inside payload is data.
        send('{'hA5, 'h02, 'hA5, 'hA5, 'h4C}, "syncdata");

        // Reset mid-frame.
        send('{'hA5, 'h03, 'hAA}, "rst.pre");
        do_reset("rst.mid");
        step(1'b0, 8'h00, "rst.after");
        send('{'hA5, 'h03, 'h01, 'h02, 'h03, 'h09}, "rst.post");

        // Saturation.
        for (int i = 0; i < 300; i++) send('{'hA5, 'h00}, "sat");
        chk("sat.err_const", 32'(bus.o_ErrCount), 32'hFF);

        do_reset("rand.start");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 150) == 0) do_reset("rand.reset");
            rand_frame();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/latch_frame_decoder.md
LATCH_FRAME_DECODER -- requirements
Module: latch_frame_decoder

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5; frame start marker.
REQ-002 Parameter MAX_LEN, default 4; maximum payload bytes per frame, legal range 1..4.
REQ-003 Parameter TIMEOUT, default 16; idle latch cycles tolerated mid-frame, range 1..255.
REQ-004 Clock i_LatchClock; all state updates on its rising edge.
REQ-005 Reset i_Reset, asynchronous, active-low.
REQ-006 i_LatchClock  in  1  clock; same latch strobe that updates the upstream 8-bit shift register outputs.
REQ-007 i_Reset  in  1  asynchronous active-low reset.
REQ-008 i_Data  in  8  parallel byte from the upstream shift register latched outputs.
REQ-009 i_ByteValid  in  1  high when i_Data holds a fresh byte to consume on this edge.
REQ-010 o_FrameValid  out  1  one-cycle pulse: a good frame was decoded.
REQ-011 o_Payload  out  32  payload of last good frame; byte k in bits [8k+7:8k].
REQ-012 o_Length  out  3  payload length of last good frame (1..MAX_LEN).
REQ-013 o_Busy  out  1  high whenever the FSM is not IDLE.
REQ-014 o_ErrCount  out  8  saturating count of rejected frames.

Function
REQ-015 FSM states: IDLE, LEN, PAYLOAD, CHECK; all transitions require i_ByteValid=1, except timeout (REQ-022).
REQ-016 IDLE: byte == SYNC_BYTE -> LEN; any other byte is discarded, no error counted.
REQ-017 LEN: byte in 1..MAX_LEN -> PAYLOAD; store length, set running sum = byte, clear index. Byte 0 or > MAX_LEN -> IDLE, error.
REQ-018 PAYLOAD: write byte into payload buffer at index; sum = (sum + byte) mod 256; index++. After byte index == length-1 -> CHECK.
REQ-019 CHECK: byte == sum -> IDLE; o_Payload, o_Length update; o_FrameValid pulses. Mismatch -> IDLE, error; o_Payload and o_Length unchanged.
REQ-020 o_FrameValid is registered: high for exactly one cycle following the edge that consumed the good checksum byte.
REQ-021 On a good frame, unused payload bytes (index >= length) are driven to zero in o_Payload.
REQ-022 Timeout: in LEN/PAYLOAD/CHECK, count consecutive cycles with i_ByteValid=0. On reaching TIMEOUT -> IDLE, error. Counter clears on every valid byte and in IDLE.
REQ-023 An error increments o_ErrCount by 1 and saturates at 8'hFF (no wrap).
REQ-024 A SYNC_BYTE value received in LEN/PAYLOAD/CHECK is treated as ordinary data, not as a resync.
REQ-025 i_ByteValid=0 holds all state except the timeout counter.
REQ-026 o_Busy is decoded from the registered state only; no combinational path from i_Data/i_ByteValid to any output.

Reset
REQ-027 Reset asserted (any time, including mid-frame) forces IDLE immediately.
REQ-028 Reset values: o_FrameValid=0, o_Payload=0, o_Length=0, o_Busy=0, o_ErrCount=0; sum, index and timeout counter cleared.
REQ-029 A partial frame interrupted by reset produces no o_FrameValid and no error count.
REQ-030 After deassertion, the first valid byte is evaluated in IDLE.

Verification
REQ-031 Good frame: bytes A5 02 11 22 35, valid every cycle -> o_FrameValid pulse one cycle after byte 35; o_Payload=32'h00002211, o_Length=2, o_ErrCount=0.
REQ-032 Bad checksum: A5 01 10 FF -> no o_FrameValid, o_ErrCount=1; o_Payload and o_Length keep their previous values.
REQ-033 Bad length: A5 00, then A5 05 -> o_ErrCount=2; o_Busy=0 after each length byte; 4-byte frame A5 04 01 02 03 04 0E then decodes to 32'h04030201.
REQ-034 Timeout: A5 02 11, then i_ByteValid=0 for 16 cycles -> o_Busy falls, o_ErrCount+1; a subsequent good frame still decodes.
REQ-035 Reset mid-frame: A5 03 AA, then pulse i_Reset low -> all outputs return to reset values; no pulse, no error; next good frame decodes normally.
REQ-036 Saturation: 300 bad-length frames -> o_ErrCount holds 8'hFF.
